sd_param_detector: RTL

- Parametrised, runtime-programmable serial sequence detector; successor to the fixed-pattern 4-bit Mealy detector.
- Tracks a PAT_LEN-bit pattern over a 1-bit serial stream, first pattern bit (MSB) first.
- Provides a Mealy output (same-cycle), a registered Moore-style output, overlap/non-overlap mode, and a saturating hit counter.
- Sits behind the serial front end; state_out is exported for debug/monitor, as in earlier detectors.

---
 rtl/sd_pkg.sv | 11 +
 rtl/sd_prefix_match.sv | 58 +++++
 rtl/sd_param_detector.sv | 78 +++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
package sd_pkg;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    localparam int PAT_LEN_MAX = 16;

endpackage

// File: rtl/sd_prefix_match.sv
// Combinational KMP helper: longest pattern prefix that ends the matched
// prefix plus the new bit, and the longest proper border of the pattern.
module sd_prefix_match
    import sd_pkg::*;
#(
    parameter  int PAT_LEN = 4,
    localparam int SW      = $clog2(PAT_LEN) + 1
) (
    input  logic [PAT_LEN-1:0] pattern,
    input  logic [SW-1:0]      state,
    input  logic               bit_in,
    output logic [SW-1:0]      match_len,
    output logic [SW-1:0]      border
);

    // Pattern bit idx counted from the first (MSB) bit.
    function automatic logic pat_bit(input logic [PAT_LEN-1:0] p, input int unsigned idx);
        logic [PAT_LEN-1:0] sh;
        sh = p >> (PAT_LEN - 1 - idx);
        return sh[0];
    endfunction

    always_comb begin : l_calc
        int unsigned n;
        logic        ok;
        n         = 32'(state) + 1;
        ok        = 1'b0;
        match_len = '0;
        for (int unsigned k = 1; k <= PAT_LEN; k++) begin
            ok = (k <= n);
            // w[n-k+i] for i < k-1 lies inside the matched prefix, so it equals pattern bit n-k+i
            for (int unsigned i = 0; i < PAT_LEN; i++) begin
                if (ok && (i + 1 < k) && (pat_bit(pattern, n - k + i) != pat_bit(pattern, i)))
                    ok = 1'b0;
            end
            if (ok && (bit_in != pat_bit(pattern, k - 1)))
                ok = 1'b0;
            if (ok)
                match_len = k[SW-1:0];
        end
    end

    always_comb begin : border_calc
        logic ok;
        ok     = 1'b0;
        border = '0;
        for (int unsigned b = 1; b < PAT_LEN; b++) begin
            ok = 1'b1;
            for (int unsigned i = 0; i < PAT_LEN; i++) begin
                if ((i < b) && (pat_bit(pattern, i) != pat_bit(pattern, PAT_LEN - b + i)))
                    ok = 1'b0;
            end
            if (ok)
                border = b[SW-1:0];
        end
    end

endmodule

// File: rtl/sd_param_detector.sv
// Runtime-programmable serial sequence detector with Mealy/registered hit
// outputs, overlap control and a saturating hit counter.
module sd_param_detector
    import sd_pkg::*;
#(
    parameter  int                 PAT_LEN = 4,
    parameter  logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter  int                 CNT_W   = 8,
    localparam int                 SW      = $clog2(PAT_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seq_in,
    input  logic               seq_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic               det_out,
    output logic               det_q,
    output logic [CNT_W-1:0]   det_cnt,
    output logic [SW-1:0]      state_out
);

    localparam logic [SW-1:0] FULL = SW'(PAT_LEN);

    logic [PAT_LEN-1:0] pat_q;
    logic [SW-1:0]      state_q;
    logic [SW-1:0]      state_d;
    logic [SW-1:0]      match_len;
    logic [SW-1:0]      border;
    logic [CNT_W-1:0]   cnt_q;
    logic               hit;

    sd_prefix_match #(
        .PAT_LEN(PAT_LEN)
    ) u_match (
        .pattern  (pat_q),
        .state    (state_q),
        .bit_in   (seq_in),
        .match_len(match_len),
        .border   (border)
    );

    assign hit     = (match_len == FULL);
    assign det_out = seq_valid & ~pat_load & hit;

    always_comb begin
        state_d = state_q;
        if (pat_load) begin
            state_d = '0;
        end else if (seq_valid) begin
            if (hit)
                state_d = (overlap == OVL_ON) ? border : '0;
            else
                state_d = match_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            pat_q   <= PATTERN;
            det_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            det_q   <= det_out;
            if (pat_load)
                pat_q <= pat_in;
            if (det_out && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign det_cnt   = cnt_q;
    assign state_out = state_q;

endmodule
